// File: rtl/volume_ramp_ctl.sv
// Volume level control with edge-detected up/down buttons and a rate-limited
// amplitude ramp towards level*STEP (zero when no note is on or when muted).
module volume_ramp_ctl #(
  parameter int                DATA_W   = 16,
  parameter int                LEVEL_W  = 4,
  parameter int                NCH      = 3,
  parameter logic [DATA_W-1:0] STEP     = 16'h0800,
  parameter logic [DATA_W-1:0] RAMP_INC = 16'h0100,
  parameter int                RAMP_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH-1:0]     note_on,
  input  logic               up,
  input  logic               down,
  input  logic               mute,
  output logic [LEVEL_W-1:0] level,
  output logic [DATA_W-1:0]  amp_max,
  output logic [DATA_W-1:0]  amp_min,
  output logic               busy
);

  localparam int AW    = DATA_W + 1;
  localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(RAMP_DIV - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] RAMP_UP   = 2'd1;
  localparam logic [1:0] RAMP_DOWN = 2'd2;

  logic               up_q, down_q;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [DATA_W-1:0]  amp_q, amp_d;
  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic          up_rise, down_rise, tick;
  logic [AW-1:0] target, amp_ext, amp_inc, amp_dec;

  assign up_rise   = up & ~up_q;
  assign down_rise = down & ~down_q;

  // Simultaneous up and down edges cancel each other.
  always_comb begin
    level_d = level_q;
    if (up_rise && !down_rise && level_q != LEVEL_MAX) begin
      level_d = level_q + 1'b1;
    end else if (down_rise && !up_rise && level_q != '0) begin
      level_d = level_q - 1'b1;
    end
  end

  assign target  = (|note_on && !mute) ? (AW'(level_q) * AW'(STEP)) : '0;
  assign amp_ext = {1'b0, amp_q};
  assign amp_inc = amp_ext + AW'(RAMP_INC);
  // The extra bit keeps amp-RAMP_INC representable as a signed value.
  assign amp_dec = amp_ext - AW'(RAMP_INC);

  always_comb begin
    state_d = IDLE;
    if (amp_ext < target) begin
      state_d = RAMP_UP;
    end else if (amp_ext > target) begin
      state_d = RAMP_DOWN;
    end
  end

  // A direction change never ticks on the cycle it is recognised.
  assign tick = (state_d == state_q) && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = '0;
    if (state_d == state_q && state_q != IDLE && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    amp_d = amp_q;
    if (tick && state_q == RAMP_UP) begin
      amp_d = (amp_inc > target) ? target[DATA_W-1:0] : amp_inc[DATA_W-1:0];
    end else if (tick && state_q == RAMP_DOWN) begin
      amp_d = ($signed(amp_dec) < $signed(target)) ? target[DATA_W-1:0]
                                                    : amp_dec[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      level_q <= '0;
      amp_q   <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      up_q    <= up;
      down_q  <= down;
      level_q <= level_d;
      amp_q   <= amp_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level   = level_q;
  assign amp_max = amp_q;
  assign amp_min = '0 - amp_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_volume_ramp_ctl.sv
// Directed bench for volume_ramp_ctl; expected values are hand-derived from
// the ramp timing (first tick 5 edges after a target change, then every 4).
module tb_volume_ramp_ctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  note_on;
  logic        up, down, mute;
  logic [3:0]  level;
  logic [15:0] amp_max, amp_min;
  logic        busy;

  int checks_cnt = 0;
  int errors_cnt = 0;

  volume_ramp_ctl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .note_on (note_on),
    .up      (up),
    .down    (down),
    .mute    (mute),
    .level   (level),
    .amp_max (amp_max),
    .amp_min (amp_min),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s = %h", tag, obs);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    note_on = 3'b000;
    up      = 1'b0;
    down    = 1'b0;
    mute    = 1'b0;
    wait_n(2);
    rst_n = 1'b1;
    wait_n(1);
  endtask

  task automatic pulse(input logic u, input logic d);
    up   = u;
    down = d;
    wait_n(1);
    up   = 1'b0;
    down = 1'b0;
    wait_n(1);
  endtask

  // Ramp 0 -> 0x0A00 (10 ticks) then drop the target; expect a 10-tick fall.
  task automatic fall_from_a00(input string tag);
    wait_n(41);
    check_eq({tag, "_at_a00"}, amp_max, 32'h0A00);
    check_eq({tag, "_busy_up"}, busy, 1);
  endtask

  task automatic check_fall(input string tag);
    wait_n(1);
    check_eq({tag, "_fall_busy"}, busy, 1);
    check_eq({tag, "_fall_hold"}, amp_max, 32'h0A00);
    wait_n(3);
    check_eq({tag, "_fall_e4"}, amp_max, 32'h0A00);
    wait_n(1);
    check_eq({tag, "_fall_e5"}, amp_max, 32'h0900);
    wait_n(36);
    check_eq({tag, "_fall_zero"}, amp_max, 32'h0000);
    check_eq({tag, "_fall_min0"}, amp_min, 32'h0000);
    wait_n(1);
    check_eq({tag, "_fall_idle"}, busy, 0);
  endtask

  initial begin
    // Reset and idle
    do_reset();
    for (int i = 0; i < 20; i++) begin
      check_eq("idle_level", level, 0);
      check_eq("idle_amp", amp_max, 0);
      check_eq("idle_ampmin", amp_min, 0);
      check_eq("idle_busy", busy, 0);
      wait_n(1);
    end

    // Down at level 0 saturates
    pulse(1'b0, 1'b1);
    check_eq("down_sat0", level, 0);

    // Three up pulses, then ramp to 0x1800
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
    check_eq("lvl3", level, 3);
    check_eq("no_note_idle", busy, 0);
    note_on = 3'b001;
    wait_n(1);
    check_eq("ramp_busy", busy, 1);
    check_eq("ramp_e1", amp_max, 0);
    wait_n(4);
    check_eq("ramp_e5", amp_max, 32'h0100);
    wait_n(4);
    check_eq("ramp_e9", amp_max, 32'h0200);
    wait_n(87);
    check_eq("ramp_e96", amp_max, 32'h1700);
    wait_n(1);
    check_eq("ramp_e97", amp_max, 32'h1800);
    check_eq("ramp_e97_busy", busy, 1);
    wait_n(1);
    check_eq("ramp_done_busy", busy, 0);
    check_eq("ramp_done_min", amp_min, 32'hE800);
    wait_n(10);
    check_eq("ramp_hold", amp_max, 32'h1800);
    check_eq("ramp_hold_busy", busy, 0);

    // Held up button counts once
    do_reset();
    up = 1'b1;
    wait_n(10);
    up = 1'b0;
    wait_n(1);
    check_eq("held_up", level, 1);

    // Twenty pulses saturate at 15, full-scale ramp to 0x7800
    do_reset();
    for (int i = 0; i < 20; i++) pulse(1'b1, 1'b0);
    check_eq("lvl_sat15", level, 15);
    note_on = 3'b100;
    wait_n(480);
    check_eq("full_e480", amp_max, 32'h7700);
    wait_n(2);
    check_eq("full_amp", amp_max, 32'h7800);
    check_eq("full_min", amp_min, 32'h8800);
    check_eq("full_busy", busy, 0);
    pulse(1'b0, 1'b1);
    check_eq("down_from15", level, 14);

    // Retarget to zero mid-ramp via note_on, then via mute
    do_reset();
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
    note_on = 3'b010;
    fall_from_a00("note");
    note_on = 3'b000;
    check_fall("note");
    note_on = 3'b010;
    fall_from_a00("mute");
    mute = 1'b1;
    check_fall("mute");
    check_eq("mute_level", level, 3);

    // Simultaneous up/down edges cancel
    do_reset();
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
    check_eq("lvl5", level, 5);
    pulse(1'b1, 1'b1);
    check_eq("both_level", level, 5);
    check_eq("both_busy", busy, 0);
    check_eq("both_amp", amp_max, 0);

    // Asynchronous reset mid-ramp
    do_reset();
    pulse(1'b1, 1'b0);
    note_on = 3'b001;
    wait_n(25);
    check_eq("pre_rst_amp", amp_max, 32'h0600);
    check_eq("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_level", level, 0);
    check_eq("arst_amp", amp_max, 0);
    check_eq("arst_ampmin", amp_min, 0);
    check_eq("arst_busy", busy, 0);
    wait_n(2);
    rst_n = 1'b1;
    wait_n(3);
    check_eq("post_rst_level", level, 0);
    check_eq("post_rst_busy", busy, 0);
    check_eq("post_rst_amp", amp_max, 0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/volume_ramp_ctl.md
VOLUME_RAMP_CTL -- requirements
Module: volume_ramp_ctl

Interface
REQ-001 Parameter DATA_W, 16, amplitude width in bits (two's complement).
REQ-002 Parameter LEVEL_W, 4, volume level width; levels 0..2^LEVEL_W-1.
REQ-003 Parameter NCH, 3, number of note-enable inputs.
REQ-004 Parameter STEP, 16'h0800, amplitude per volume level; STEP*(2^LEVEL_W-1) SHALL NOT exceed 2^(DATA_W-1)-1.
REQ-005 Parameter RAMP_INC, 16'h0100, amplitude change per ramp tick; SHALL be nonzero.
REQ-006 Parameter RAMP_DIV, 4, clock cycles per ramp tick; SHALL be at least 1.
REQ-007 clk  input  1  system clock; all state SHALL change on the rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 note_on  input  NCH  per-channel note enables; any bit set means sound requested.
REQ-010 up  input  1  volume-up button level, synchronous to clk.
REQ-011 down  input  1  volume-down button level, synchronous to clk.
REQ-012 mute  input  1  level; 1 forces target amplitude to 0 without changing level.
REQ-013 level  output  LEVEL_W  registered current volume level.
REQ-014 amp_max  output  DATA_W  registered current positive amplitude.
REQ-015 amp_min  output  DATA_W  two's-complement negation of amp_max, combinational.
REQ-016 busy  output  1  high while state is not IDLE.

Function
REQ-017 up and down SHALL be edge-detected: one increment/decrement per 0->1 transition, held levels ignored.
REQ-018 Level SHALL saturate: up at maximum and down at 0 leave level unchanged.
REQ-019 Rising edges of up and down in the same cycle SHALL leave level unchanged.
REQ-020 Level SHALL update one cycle after the up/down rising edge is sampled.
REQ-021 target = level*STEP when |note_on and !mute; otherwise target = 0; computed combinationally from registered level.
REQ-022 FSM states IDLE, RAMP_UP, RAMP_DOWN; next state each cycle: amp_max<target -> RAMP_UP, amp_max>target -> RAMP_DOWN, equal -> IDLE.
REQ-023 A tick counter SHALL clear to 0 on every state change and otherwise count 0..RAMP_DIV-1 while not IDLE, wrapping at RAMP_DIV-1.
REQ-024 On a tick (counter==RAMP_DIV-1) in RAMP_UP, amp_max SHALL become min(amp_max+RAMP_INC, target).
REQ-025 On a tick in RAMP_DOWN, amp_max SHALL become max(amp_max-RAMP_INC, target).
REQ-026 amp_max SHALL never overshoot target and SHALL hold while IDLE.
REQ-027 Target changes mid-ramp (level, note_on, mute) SHALL retarget immediately; direction reversal restarts the tick counter.
REQ-028 Ramp arithmetic SHALL use DATA_W+1 bits internally so no wrap-around occurs.
REQ-029 amp_min SHALL equal 0 when amp_max is 0.

Reset
REQ-030 rst_n low SHALL immediately force level=0, amp_max=0, amp_min=0, busy=0, state IDLE, tick counter 0, edge-detect history 0.
REQ-031 Reset asserted mid-ramp SHALL abandon the ramp; after release the block starts from the reset values.

Verification (defaults)
REQ-032 Reset, then idle 20 cycles -> level=0, amp_max=0, amp_min=0, busy=0 throughout.
REQ-033 note_on=3'b001, three up pulses -> level=3, target 16'h1800; amp_max rises 16'h0100 every 4 cycles, reaches 16'h1800 after 24 ticks (96 cycles), then busy=0, amp_min=16'hE800.
REQ-034 up held high 10 cycles -> level +1 only; 20 up pulses from 0 -> level 15, target 16'h7800.
REQ-035 At amp_max=16'h0A00 rising, note_on->0 -> state RAMP_DOWN, counter restarts, amp_max reaches 0 after 10 ticks; mute=1 behaves identically with level unchanged.
REQ-036 up and down rising in the same cycle at level 5 -> level stays 5, no ramp started.
REQ-037 rst_n pulsed low during RAMP_UP at amp_max=16'h0600 -> all outputs 0 asynchronously; after release, level=0 and busy=0.
